// File: rtl/fpmul_arbiter_pkg.sv
// Shared types and constants for the FPMUL round-robin arbiter.
package fpmul_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int FLAG_W = 6;

    // Bit positions inside the {OF,UF,NaNF,InfF,DNF,ZF} flag vector.
    localparam int F_OF  = 5;
    localparam int F_UF  = 4;
    localparam int F_NAN = 3;
    localparam int F_INF = 2;
    localparam int F_DN  = 1;
    localparam int F_Z   = 0;

    localparam logic [31:0]       QNAN      = 32'h7FC00000;
    localparam logic [FLAG_W-1:0] TMO_FLAGS = FLAG_W'(1) << F_NAN;

endpackage

// File: rtl/fpmul_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping upward.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          found
);

    int cand;

    always_comb begin
        // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < N; i++) begin
            cand = int'(ptr) + i;
            if (cand >= N) cand = cand - N;
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = PW'(cand);
            end
        end
    end

endmodule

// File: rtl/fpmul_arbiter.sv
// Shares one FPMUL between N requesters: round-robin grant, start/done handshake,
// registered result return and a watchdog that resets the multiplier on a hang.
module fpmul_arbiter
    import fpmul_arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      req,
    input  logic [N*32-1:0]   ain,
    input  logic [N*32-1:0]   bin,
    output logic [N-1:0]      gnt,
    output logic [N-1:0]      vld,
    output logic [31:0]       pout,
    output logic [FLAG_W-1:0] flags,
    output logic              tmo,
    output logic              busy,
    output logic              fm_rst,
    output logic              fm_start,
    output logic [31:0]       fm_a,
    output logic [31:0]       fm_b,
    input  logic              fm_done,
    input  logic [31:0]       fm_p,
    input  logic [FLAG_W-1:0] fm_flags
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d, win_q, win_d, arb_idx;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N-1:0]      arb_gnt, gnt_d, vld_d;
    logic              arb_found;
    logic [31:0]       pout_d, fm_a_d, fm_b_d;
    logic [FLAG_W-1:0] flags_d;
    logic              tmo_d, busy_d, fm_rst_d, fm_start_d;
    logic              done_ok, expired;

    rr_arbiter #(.N(N), .PW(PW)) u_rr (
        .req   (req),
        .ptr   (ptr_q),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .found (arb_found)
    );

    // fm_start is still high in the first WAIT cycle, which masks a Done left over from before.
    assign done_ok = (state_q == WAIT) && !fm_start && fm_done;
    assign expired = (state_q == WAIT) && !done_ok && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (arb_found) state_d = WAIT;
            WAIT:    if (done_ok || expired) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d      = '0;
        vld_d      = '0;
        tmo_d      = 1'b0;
        fm_rst_d   = 1'b0;
        fm_start_d = 1'b0;
        pout_d     = pout;
        flags_d    = flags;
        fm_a_d     = fm_a;
        fm_b_d     = fm_b;
        ptr_d      = ptr_q;
        win_d      = win_q;
        cnt_d      = cnt_q;
        busy_d     = (state_d != IDLE);
        unique case (state_q)
            IDLE: begin
                if (arb_found) begin
                    gnt_d      = arb_gnt;
                    fm_a_d     = ain[32*int'(arb_idx) +: 32];
                    fm_b_d     = bin[32*int'(arb_idx) +: 32];
                    fm_start_d = 1'b1;
                    win_d      = arb_idx;
                    ptr_d      = (int'(arb_idx) == N - 1) ? '0 : arb_idx + PW'(1);
                    cnt_d      = '0;
                end
            end
            WAIT: begin
                if (done_ok) begin
                    pout_d  = fm_p;
                    flags_d = fm_flags;
                    vld_d   = N'(1) << win_q;
                end else if (expired) begin
                    pout_d   = QNAN;
                    flags_d  = TMO_FLAGS;
                    tmo_d    = 1'b1;
                    vld_d    = N'(1) << win_q;
                    fm_rst_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            win_q    <= '0;
            cnt_q    <= '0;
            gnt      <= '0;
            vld      <= '0;
            pout     <= '0;
            flags    <= '0;
            tmo      <= 1'b0;
            busy     <= 1'b0;
            fm_rst   <= 1'b1;
            fm_start <= 1'b0;
            fm_a     <= '0;
            fm_b     <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            cnt_q    <= cnt_d;
            gnt      <= gnt_d;
            vld      <= vld_d;
            pout     <= pout_d;
            flags    <= flags_d;
            tmo      <= tmo_d;
            busy     <= busy_d;
            fm_rst   <= fm_rst_d;
            fm_start <= fm_start_d;
            fm_a     <= fm_a_d;
            fm_b     <= fm_b_d;
        end
    end

endmodule

// File: tb/tb_fpmul_arbiter.sv
// Bench for fpmul_arbiter: FPMUL stub, transaction-level model with per-cycle compare, directed scenarios.
module tb_fpmul_arbiter;

    localparam int N  = 4;
    localparam int TO = 8;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*32-1:0] ain, bin;
    logic [N-1:0]    gnt, vld;
    logic [31:0]     pout, fm_a, fm_b, fm_p;
    logic [5:0]      flags, fm_flags;
    logic            tmo, busy, fm_rst, fm_start, fm_done;

    int checks   = 0;
    int failures = 0;
    bit cmp_on   = 1'b0;

    fpmul_arbiter #(.N(N), .TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .ain      (ain),
        .bin      (bin),
        .gnt      (gnt),
        .vld      (vld),
        .pout     (pout),
        .flags    (flags),
        .tmo      (tmo),
        .busy     (busy),
        .fm_rst   (fm_rst),
        .fm_start (fm_start),
        .fm_a     (fm_a),
        .fm_b     (fm_b),
        .fm_done  (fm_done),
        .fm_p     (fm_p),
        .fm_flags (fm_flags)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Multiplier stand-in: known IEEE products for the directed operands, a scramble otherwise.
    function automatic logic [37:0] stub_mul(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h40000000 && b == 32'h40000000) return {32'h40800000, 6'h00};
        if (a == 32'h40f903cc && b == 32'h40824fcd) return {32'h41fd831a, 6'h00};
        if (a == 32'h3fc00000 && b == 32'h40000000) return {32'h40400000, 6'h00};
        if (a == 32'h319a90b8 && b == 32'hffcd3697) return {32'hffcd3697, 6'h08};
        return {a ^ {b[15:0], b[31:16]}, a[5:0] ^ b[5:0]};
    endfunction

    // FPMUL stub driven on the falling edge; latency counted from the cycle Start is seen.
    int         lat        = 2;
    bit         never_done = 1'b0;
    bit         stale      = 1'b0;
    int         stub_cnt;
    bit         stub_act;
    logic [31:0] stub_a, stub_b;

    initial begin
        fm_done = 1'b0; fm_p = '0; fm_flags = '0;
        stub_cnt = 0; stub_act = 1'b0; stub_a = '0; stub_b = '0;
        forever begin
            @(negedge clk);
            fm_done = 1'b0;
            if (fm_rst === 1'b1) begin
                stub_act = 1'b0;
                stub_cnt = 0;
            end else if (fm_start) begin
                stub_a = fm_a;
                stub_b = fm_b;
                stub_act = !never_done;
                stub_cnt = lat;
                if (stale) begin
                    fm_done  = 1'b1;
                    fm_p     = 32'hdeadbeef;
                    fm_flags = 6'h3f;
                end
            end else if (stub_act) begin
                stub_cnt--;
                if (stub_cnt == 0) begin
                    fm_done  = 1'b1;
                    {fm_p, fm_flags} = stub_mul(stub_a, stub_b);
                    stub_act = 1'b0;
                end
            end
        end
    end

    // Transaction model: phase 0 idle, 1 multiplier running, 2 result cycle.
    int          m_phase = 0, m_ptr = 0, m_win = 0, m_waited = 0, w;
    logic [31:0] m_a = '0, m_b = '0;
    logic [37:0] m_res;
    logic [N-1:0] e_gnt = '0, e_vld = '0;
    logic [31:0] e_pout = '0, e_fm_a = '0, e_fm_b = '0;
    logic [5:0]  e_flags = '0;
    logic        e_tmo = 1'b0, e_busy = 1'b0, e_fm_rst = 1'b1, e_fm_start = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0; m_ptr <= 0; m_win <= 0; m_waited <= 0;
            e_gnt <= '0; e_vld <= '0; e_pout <= '0; e_flags <= '0; e_tmo <= 1'b0;
            e_busy <= 1'b0; e_fm_rst <= 1'b1; e_fm_start <= 1'b0; e_fm_a <= '0; e_fm_b <= '0;
        end else begin
            e_gnt <= '0; e_vld <= '0; e_tmo <= 1'b0; e_fm_start <= 1'b0; e_fm_rst <= 1'b0;
            if (m_phase == 0) begin
                if (req != '0) begin
                    w = -1;
                    for (int k = 0; k < N; k++)
                        if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                    e_gnt      <= N'(1) << w;
                    e_fm_a     <= ain[32*w +: 32];
                    e_fm_b     <= bin[32*w +: 32];
                    m_a        <= ain[32*w +: 32];
                    m_b        <= bin[32*w +: 32];
                    e_fm_start <= 1'b1;
                    e_busy     <= 1'b1;
                    m_ptr      <= (w + 1) % N;
                    m_win      <= w;
                    m_waited   <= 0;
                    m_phase    <= 1;
                end
            end else if (m_phase == 1) begin
                if (m_waited + 1 >= 2 && fm_done) begin
                    m_res    = stub_mul(m_a, m_b);
                    e_pout  <= m_res[37:6];
                    e_flags <= m_res[5:0];
                    e_vld   <= N'(1) << m_win;
                    m_phase <= 2;
                end else if (m_waited + 1 == TO) begin
                    e_pout   <= 32'h7FC00000;
                    e_flags  <= 6'h08;
                    e_tmo    <= 1'b1;
                    e_vld    <= N'(1) << m_win;
                    e_fm_rst <= 1'b1;
                    m_phase  <= 2;
                end
                m_waited <= m_waited + 1;
            end else begin
                m_phase <= 0;
                e_busy  <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            check("cyc_gnt",      32'(gnt),      32'(e_gnt));
            check("cyc_vld",      32'(vld),      32'(e_vld));
            check("cyc_pout",     pout,          e_pout);
            check("cyc_flags",    32'(flags),    32'(e_flags));
            check("cyc_tmo",      32'(tmo),      32'(e_tmo));
            check("cyc_busy",     32'(busy),     32'(e_busy));
            check("cyc_fm_rst",   32'(fm_rst),   32'(e_fm_rst));
            check("cyc_fm_start", 32'(fm_start), 32'(e_fm_start));
            check("cyc_fm_a",     fm_a,          e_fm_a);
            check("cyc_fm_b",     fm_b,          e_fm_b);
        end
    end

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        ain[32*i +: 32] = a;
        bin[32*i +: 32] = b;
    endtask

    task automatic wait_gnt(input string name, output int idx);
        idx = -1;
        for (int i = 0; i < 40 && idx < 0; i++) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) if (gnt[k]) idx = k;
        end
        check({name, "_gnt_seen"}, 32'(idx >= 0), 32'd1);
    endtask

    task automatic wait_vld(input string name, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (vld == '0 && n < 40);
        check({name, "_vld_seen"}, 32'(vld != '0), 32'd1);
    endtask

    int idx, n;

    initial begin
        req = '0; ain = '0; bin = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_fm_rst",   32'(fm_rst),   32'd1);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_gnt",      32'(gnt),      32'd0);
        check("rst_vld",      32'(vld),      32'd0);
        check("rst_pout",     pout,          32'd0);
        check("rst_fm_start", 32'(fm_start), 32'd0);
        cmp_on = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("release_fm_rst", 32'(fm_rst), 32'd0);

        // Single request from requester 0: 2.0 * 2.0
        lat = 2;
        set_op(0, 32'h40000000, 32'h40000000);
        req = 4'b0001;
        wait_gnt("t1", idx);
        check("t1_idx",      idx,           0);
        check("t1_fm_start", 32'(fm_start), 32'd1);
        check("t1_fm_a",     fm_a,          32'h40000000);
        req = '0;
        wait_vld("t1", n);
        check("t1_latency", n,            3);
        check("t1_vld",     32'(vld),     32'h1);
        check("t1_pout",    pout,         32'h40800000);
        check("t1_flags",   32'(flags),   32'h0);
        check("t1_tmo",     32'(tmo),     32'h0);
        @(negedge clk);
        check("t1_idle", 32'(busy), 32'd0);

        // Requester 2 alone, then pointer must sit at 3
        set_op(2, 32'h40f903cc, 32'h40824fcd);
        req = 4'b0100;
        wait_gnt("t2", idx);
        check("t2_idx", idx, 2);
        req = '0;
        wait_vld("t2", n);
        check("t2_vld",  32'(vld), 32'h4);
        check("t2_pout", pout,     32'h41fd831a);
        set_op(3, 32'h3f800000, 32'h40400000);
        req = 4'b1001;
        wait_gnt("t2_ptr", idx);
        check("t2_ptr_idx", idx, 3);
        req = 4'b0001;
        wait_vld("t2_ptr", n);
        wait_gnt("t2_wrap", idx);
        check("t2_wrap_idx", idx, 0);
        req = '0;
        wait_vld("t2_wrap", n);

        // Stale Done during the first WAIT cycle must be ignored
        stale = 1'b1;
        lat = 3;
        set_op(1, 32'h3fc00000, 32'h40000000);
        req = 4'b0010;
        wait_gnt("t3", idx);
        check("t3_idx", idx, 1);
        req = '0;
        wait_vld("t3", n);
        stale = 1'b0;
        check("t3_latency", n,    4);
        check("t3_pout",    pout, 32'h40400000);

        // NaN operand: flags pass straight through, minimum latency
        lat = 1;
        set_op(1, 32'h319a90b8, 32'hffcd3697);
        req = 4'b0010;
        wait_gnt("t4", idx);
        req = '0;
        wait_vld("t4", n);
        check("t4_latency", n,          2);
        check("t4_vld",     32'(vld),   32'h2);
        check("t4_flags",   32'(flags), 32'h08);
        check("t4_pout",    pout,       32'hffcd3697);

        // Watchdog abort
        never_done = 1'b1;
        set_op(2, 32'h3f800000, 32'h3f800000);
        req = 4'b0100;
        wait_gnt("t5", idx);
        req = '0;
        wait_vld("t5", n);
        check("t5_wait_cycles", n,           TO);
        check("t5_vld",         32'(vld),    32'h4);
        check("t5_tmo",         32'(tmo),    32'd1);
        check("t5_pout",        pout,        32'h7FC00000);
        check("t5_flags",       32'(flags),  32'h08);
        check("t5_fm_rst",      32'(fm_rst), 32'd1);
        @(negedge clk);
        check("t5_busy_after",   32'(busy),   32'd0);
        check("t5_fm_rst_after", 32'(fm_rst), 32'd0);
        check("t5_tmo_after",    32'(tmo),    32'd0);
        never_done = 1'b0;

        // Asynchronous reset in the middle of WAIT
        lat = 5;
        set_op(3, 32'h40000000, 32'h3fc00000);
        req = 4'b1000;
        wait_gnt("t6", idx);
        req = '0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_fm_rst",   32'(fm_rst),   32'd1);
        check("t6_busy",     32'(busy),     32'd0);
        check("t6_gnt",      32'(gnt),      32'd0);
        check("t6_vld",      32'(vld),      32'd0);
        check("t6_fm_start", 32'(fm_start), 32'd0);
        check("t6_fm_a",     fm_a,          32'd0);
        check("t6_pout",     pout,          32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_release_fm_rst", 32'(fm_rst), 32'd0);

        // All four requesting and held: order 0,1,2,3,0 from a fresh pointer
        lat = 1;
        for (int i = 0; i < N; i++) set_op(i, 32'h3f800000 + 32'(i), 32'h40000000 + 32'(i << 8));
        req = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            wait_gnt("rr", idx);
            check("rr_order", idx, r % N);
            if (r == 4) req = '0;
            wait_vld("rr", n);
            check("rr_vld_match", 32'(vld), 32'(1 << (r % N)));
        end
        repeat (3) @(negedge clk);
        check("end_idle", 32'(busy), 32'd0);

        cmp_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpmul_arbiter.md
Name: fpmul_arbiter

Overview:
Shares one FPMUL multiplier between N requesters using round-robin arbitration.
- Latches the winning requester's operands, pulses the multiplier's Start, and waits for Done.
- Returns the product and exception flags to the winner with a one-cycle valid strobe.
- Runs a watchdog that resets the multiplier and returns an error result if Done never arrives.

Parameters:
N, 4, number of requesters (2..8)
TIMEOUT, 64, maximum WAIT cycles before abort (>=2)

Ports:
Clk  in  1  system clock, rising edge
Rst_n  in  1  asynchronous active-low reset
Req  in  N  per-requester request level
Ain  in  N*32  operand A, requester i at bits [32i+31:32i]
Bin  in  N*32  operand B, same packing
Gnt  out  N  one-hot, one-cycle pulse: operands taken
Vld  out  N  one-hot, one-cycle pulse: result valid for that requester
Pout  out  32  product, shared by all requesters, qualified by Vld
Flags  out  6  {OF,UF,NaNF,InfF,DNF,ZF}, qualified by Vld
Tmo  out  1  high with Vld when the result is a timeout abort
Busy  out  1  high in any state other than IDLE
Fm_Rst  out  1  active-high reset to FPMUL
Fm_Start  out  1  FPMUL start pulse
Fm_A  out  32  FPMUL operand A
Fm_B  out  32  FPMUL operand B
Fm_Done  in  1  FPMUL done
Fm_P  in  32  FPMUL product
Fm_Flags  in  6  FPMUL {OF,UF,NaNF,InfF,DNF,ZF}

Behaviour:
- Output register discipline: all outputs are registered.
- Reset values (Rst_n low):
  - Gnt, Vld, Pout, Flags, Tmo, Busy, Fm_Start, Fm_A, Fm_B = 0.
  - Fm_Rst = 1; state = IDLE; round-robin pointer = 0; watchdog counter = 0.
- After Rst_n deasserts: Fm_Rst goes 0 on the first rising edge and stays 0 except during a timeout abort.
- IDLE state:
  - With Req != 0, the winner is the first asserted Req at or after the pointer, searching upward with wrap.
  - At that edge: Fm_A/Fm_B <= winner's operands; Fm_Start <= 1; Gnt <= onehot(winner); pointer <= (winner+1) mod N; counter <= 0; state <= WAIT.
- WAIT state:
  - Fm_Start and Gnt return to 0 one cycle after the grant edge.
  - Fm_Done is ignored in the first WAIT cycle, where Fm_Start is still 1; this guards against a stale Done.
  - From the second WAIT cycle on, when Fm_Done = 1: Pout <= Fm_P; Flags <= Fm_Flags; Vld <= onehot(winner); Tmo <= 0; state <= RESP.
  - Otherwise counter increments.
  - If counter == TIMEOUT-1 without Done: Pout <= 32'h7FC00000; Flags <= NaNF only; Tmo <= 1; Vld <= onehot(winner); Fm_Rst <= 1; state <= RESP.
- RESP state: lasts exactly 1 cycle. Vld (and Tmo, if set) is high this cycle; all pulses clear and Fm_Rst returns to 0 at its end; state <= IDLE.
- Pout and Flags hold their value until the next Vld.
- Minimum service latency: Req sampled at edge E, Gnt high in E..E+1, Vld high one cycle after Fm_Done is sampled. The next grant is no earlier than the edge after RESP.
- Requester contract:
  - Hold Req and operands stable until Gnt.
  - Req may drop after Gnt without cancelling the operation.
  - Req still high in IDLE after that requester's Vld starts a new request, arbitrated behind other pending requesters.
- Req changes during WAIT/RESP are ignored until IDLE.
- Rst_n asserted mid-operation aborts immediately with no Vld and holds FPMUL in reset via Fm_Rst = 1.
- N = 1: the pointer stays 0.

Decomposition:
- Package fpmul_arb_pkg holds:
  - state enum {IDLE, WAIT, RESP};
  - flag bit indices OF=5..ZF=0;
  - constant QNAN = 32'h7FC00000;
  - flag width 6.
- Sub-module rr_arbiter(N): combinational one-hot grant from Req and pointer, plus binary index of the winner. The pointer register stays in fpmul_arbiter.

Test Plan:
- Single request: requester 0, A=32'h40000000, B=32'h40000000 -> Gnt[0] one cycle, Fm_Start one cycle, then Vld[0] with Pout=32'h40800000, Flags=0, Tmo=0.
- Requester 2 alone, A=32'h40f903cc, B=32'h40824fcd -> Pout=32'h41fd831a on Vld[2]; pointer then 3.
- Simultaneous Req=4'b1111 held high, pointer 0 -> grant order 0,1,2,3,0; each Vld matches its Gnt; no overlap of operations.
- Special operands: requester 1 with 32'h319a90b8 x 32'hffcd3697 -> Vld[1] with Flags NaNF set, Pout from FPMUL passed through unmodified.
- Timeout: FPMUL stub never asserts Done, TIMEOUT=8 -> Vld plus Tmo after 8 WAIT cycles, Pout=32'h7FC00000, Fm_Rst one-cycle pulse, Busy low next cycle.
- Reset mid-WAIT: assert Rst_n low asynchronously -> all outputs 0 and Fm_Rst=1 immediately without a clock edge; after release, Fm_Rst=0 and fresh arbitration starts at pointer 0.
